reg_arb: RTL

REG_ARB -- requirements
Module: reg_arb

---
 rtl/reg_arb_pkg.sv | 19 +
 rtl/reg_arb_if.sv | 27 ++
 rtl/reg_arb_rr_pick.sv | 30 +++
 rtl/reg_arb.sv | 108 ++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the reg_arb register arbiter.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int N_REQ_DEF = 4;
  localparam int DW_DEF    = 8;
  localparam int CNT_W     = 16;

  // Width of a requester index; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_arb_if.sv
// Requester-side bus of the reg_arb arbiter: requests and data in, grant/ack/register out.
interface reg_arb_if
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW    = DW_DEF
) ();

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    ack;
  logic [DW-1:0]       q;
  logic                busy;
  logic [CNT_W-1:0]    wr_cnt;

  modport master (
    output req, wdata,
    input  gnt, ack, q, busy, wr_cnt
  );

  modport slave (
    input  req, wdata,
    output gnt, ack, q, busy, wr_cnt
  );

endinterface

// File: rtl/reg_arb_rr_pick.sv
// Combinational round-robin picker: first active request after last_owner, wrapping modulo N_REQ.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  localparam int IW   = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_owner,
  output logic [IW-1:0]    owner,
  output logic             valid
);

  int idx;

  always_comb begin
    owner = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_owner) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!valid && req[IW'(idx)]) begin
        valid = 1'b1;
        owner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_arb.sv
// Round-robin arbiter guarding one shared register; one write per three cycles.
// Define REG_ARB_WCOUNT_EN to build the saturating completed-write counter on wr_cnt.
module reg_arb
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW    = DW_DEF,
  localparam int IW   = idx_w(N_REQ)
) (
  input  logic     clk,
  input  logic     rstn,
  reg_arb_if.slave bus
);

  state_t            state, state_nxt;
  logic [IW-1:0]     owner, owner_nxt;
  logic [IW-1:0]     last_owner, last_nxt;
  logic [N_REQ-1:0]  gnt_r, gnt_nxt;
  logic [N_REQ-1:0]  ack_r, ack_nxt;
  logic [DW-1:0]     q_r, q_nxt;
  logic [IW-1:0]     pick_owner;
  logic              pick_vld;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (bus.req),
    .last_owner (last_owner),
    .owner      (pick_owner),
    .valid      (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_owner;
    gnt_nxt   = '0;
    ack_nxt   = '0;
    q_nxt     = q_r;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          owner_nxt           = pick_owner;
          gnt_nxt[pick_owner] = 1'b1;
          state_nxt           = GRANT;
        end
      end
      // A withdrawn request aborts: register and rotation pointer are left untouched.
      GRANT: begin
        if (bus.req[owner]) begin
          q_nxt          = bus.wdata[owner*DW +: DW];
          ack_nxt[owner] = 1'b1;
          last_nxt       = owner;
          state_nxt      = WRITE;
        end else begin
          state_nxt = IDLE;
        end
      end
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      owner      <= '0;
      last_owner <= IW'(N_REQ - 1);
      gnt_r      <= '0;
      ack_r      <= '0;
      q_r        <= '0;
    end else begin
      owner      <= owner_nxt;
      last_owner <= last_nxt;
      gnt_r      <= gnt_nxt;
      ack_r      <= ack_nxt;
      q_r        <= q_nxt;
    end
  end

  assign bus.gnt  = gnt_r;
  assign bus.ack  = ack_r;
  assign bus.q    = q_r;
  assign bus.busy = (state != IDLE);

`ifdef REG_ARB_WCOUNT_EN
  logic [CNT_W-1:0] wr_cnt_r;
  logic             wr_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign wr_done = (state == GRANT) && bus.req[owner];

  always_ff @(posedge clk) begin
    if (!rstn)        wr_cnt_r <= '0;
    else if (wr_done) wr_cnt_r <= sat_inc(wr_cnt_r);
  end

  assign bus.wr_cnt = wr_cnt_r;
`else
  assign bus.wr_cnt = '0;
`endif

endmodule
